// File: rtl/bus_sequencer.sv
// bus_sequencer: per-instruction bus-enable sequencer between the decoder and
// the register file / RAM bus. Each instruction runs single-cycle (EXEC), or
// as a RAM load (ADDR [WAIT..] DATA) or a RAM store (ADDR DATA).
module bus_sequencer #(
  parameter int NUM_REGS    = 8,
  parameter int REG_SEL_W   = 3,
  parameter int RAM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 insn_valid,
  output logic                 insn_ready,
  input  logic [2:0]           insn_class,
  input  logic [REG_SEL_W-1:0] reg_num,
  output logic [NUM_REGS-1:0]  reg_out_en,
  output logic [NUM_REGS-1:0]  reg_write_en,
  output logic                 reg_pc_read_en,
  output logic                 reg_pc_write_en,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic                 ram_out_en,
  output logic                 insn_done,
  output logic                 illegal_reg
);

  localparam int CNT_W = $clog2(4) + 1;

  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_ALU_R = 3'd1;
  localparam logic [2:0] C_ALU_I = 3'd2;
  localparam logic [2:0] C_CPY   = 3'd3;
  localparam logic [2:0] C_CPYPC = 3'd4;
  localparam logic [2:0] C_JMP   = 3'd5;
  localparam logic [2:0] C_LB    = 3'd6;
  localparam logic [2:0] C_SB    = 3'd7;

  // accumulator select
  localparam logic [NUM_REGS-1:0] ACC = NUM_REGS'(1);

  typedef enum logic [2:0] {IDLE, EXEC, ADDR, WAIT, DATA} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           cls_q;
  logic [REG_SEL_W-1:0] reg_q;
  logic                 accept;
  logic                 reg_ok;
  logic                 reject;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(idx) == i) onehot[i] = 1'b1;
  endfunction

  // A done cycle doubles as an accept slot so single-cycle ops stream at 1/clk.
  assign insn_ready = !rst && (state == IDLE || insn_done);
  assign accept     = insn_valid && insn_ready;
  assign reg_ok     = int'(reg_num) < NUM_REGS;
  // NOP and ALU_I never touch reg_num, so an out-of-range value is harmless there.
  assign reject     = !reg_ok && insn_class != C_NOP && insn_class != C_ALU_I;

  // FSM and registered enables; every enable defaults low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      cls_q           <= '0;
      reg_q           <= '0;
      reg_out_en      <= '0;
      reg_write_en    <= '0;
      reg_pc_read_en  <= 1'b0;
      reg_pc_write_en <= 1'b0;
      ram_en          <= 1'b0;
      ram_we          <= 1'b0;
      ram_out_en      <= 1'b0;
      insn_done       <= 1'b0;
      illegal_reg     <= 1'b0;
    end else begin
      reg_out_en      <= '0;
      reg_write_en    <= '0;
      reg_pc_read_en  <= 1'b0;
      reg_pc_write_en <= 1'b0;
      ram_en          <= 1'b0;
      ram_we          <= 1'b0;
      ram_out_en      <= 1'b0;
      insn_done       <= 1'b0;
      illegal_reg     <= 1'b0;
      if (accept) begin
        cls_q <= insn_class;
        reg_q <= reg_num;
        if (reject) begin
          state       <= EXEC;
          insn_done   <= 1'b1;
          illegal_reg <= 1'b1;
        end else if (insn_class == C_LB || insn_class == C_SB) begin
          // address cycle: accumulator holds the RAM address
          state      <= ADDR;
          reg_out_en <= ACC;
          ram_en     <= 1'b1;
          cnt        <= CNT_W'(RAM_LATENCY - 1);
        end else begin
          state     <= EXEC;
          insn_done <= 1'b1;
          case (insn_class)
            C_ALU_R: begin
              reg_out_en   <= onehot(reg_num);
              reg_write_en <= ACC;
            end
            C_ALU_I: reg_write_en <= ACC;
            C_CPY: begin
              reg_out_en   <= ACC;
              reg_write_en <= onehot(reg_num);
            end
            C_CPYPC: begin
              reg_pc_read_en <= 1'b1;
              reg_write_en   <= onehot(reg_num);
            end
            C_JMP: begin
              reg_out_en      <= onehot(reg_num);
              reg_pc_write_en <= 1'b1;
            end
            default: ;
          endcase
        end
      end else begin
        case (state)
          ADDR: begin
            if (cls_q == C_SB) begin
              state      <= DATA;
              reg_out_en <= onehot(reg_q);
              ram_we     <= 1'b1;
              insn_done  <= 1'b1;
            end else if (cnt == '0) begin
              state        <= DATA;
              ram_out_en   <= 1'b1;
              reg_write_en <= onehot(reg_q);
              insn_done    <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
          // counter still holds the number of WAIT cycles left, including this one
          WAIT: begin
            if (cnt == CNT_W'(1)) begin
              state        <= DATA;
              cnt          <= '0;
              ram_out_en   <= 1'b1;
              reg_write_en <= onehot(reg_q);
              insn_done    <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: three sequencers with different NUM_REGS / RAM_LATENCY,
// checked cycle by cycle against per-instruction expected enable traces.
module tb_bus_sequencer;

  localparam int NI = 3;

  function automatic int nregs(input int g);
    return (g == 2) ? 6 : 8;
  endfunction
  function automatic int lat(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  typedef logic [22:0] tr_q_t[$];

  logic       clk;
  logic       rst [NI];
  logic       vld [NI];
  logic [2:0] cls [NI];
  logic [2:0] rn  [NI];
  logic [7:0] oe  [NI];
  logic [7:0] we  [NI];
  logic       rdy [NI];
  logic       pcr [NI];
  logic       pcw [NI];
  logic       ren [NI];
  logic       rwe [NI];
  logic       roe [NI];
  logic       done[NI];
  logic       ill [NI];

  int n_chk  = 0;
  int n_fail = 0;
  int issued [NI];
  int dn     [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NR = nregs(g);
    logic [NR-1:0] oe_l, we_l;
    bus_sequencer #(.NUM_REGS(NR), .REG_SEL_W(3), .RAM_LATENCY(lat(g))) u_dut (
      .clk(clk), .rst(rst[g]), .insn_valid(vld[g]), .insn_ready(rdy[g]),
      .insn_class(cls[g]), .reg_num(rn[g]), .reg_out_en(oe_l), .reg_write_en(we_l),
      .reg_pc_read_en(pcr[g]), .reg_pc_write_en(pcw[g]), .ram_en(ren[g]),
      .ram_we(rwe[g]), .ram_out_en(roe[g]), .insn_done(done[g]), .illegal_reg(ill[g])
    );
    assign oe[g] = 8'(oe_l);
    assign we[g] = 8'(we_l);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] mk(input logic [7:0] o, input logic [7:0] w,
                                     input logic pr, input logic pw, input logic en,
                                     input logic wr, input logic ro, input logic dn_,
                                     input logic il);
    return {o, w, pr, pw, en, wr, ro, dn_, il};
  endfunction

  function automatic logic [22:0] obs(input int g);
    return {oe[g], we[g], pcr[g], pcw[g], ren[g], rwe[g], roe[g], done[g], ill[g]};
  endfunction

  // Expected per-cycle enables of one instruction, straight from the class table.
  function automatic tr_q_t trace(input logic [2:0] c, input logic [2:0] r,
                                  input int nr, input int l);
    tr_q_t q;
    logic [7:0] oh;
    oh = 8'(1) << r;
    if (int'(r) >= nr && c != 3'd0 && c != 3'd2) begin
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
      return q;
    end
    case (c)
      3'd0: q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      3'd1: q.push_back(mk(oh, 8'h01, 0, 0, 0, 0, 0, 1, 0));
      3'd2: q.push_back(mk(0, 8'h01, 0, 0, 0, 0, 0, 1, 0));
      3'd3: q.push_back(mk(8'h01, oh, 0, 0, 0, 0, 0, 1, 0));
      3'd4: q.push_back(mk(0, oh, 1, 0, 0, 0, 0, 1, 0));
      3'd5: q.push_back(mk(oh, 0, 0, 1, 0, 0, 0, 1, 0));
      3'd6: begin
        q.push_back(mk(8'h01, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < l - 1; i++) q.push_back('0);
        q.push_back(mk(0, oh, 0, 0, 0, 0, 1, 1, 0));
      end
      default: begin
        q.push_back(mk(8'h01, 0, 0, 0, 1, 0, 0, 0, 0));
        q.push_back(mk(oh, 0, 0, 0, 0, 1, 0, 1, 0));
      end
    endcase
    return q;
  endfunction

  // Called mid-cycle with the sequencer ready; returns mid-cycle.
  task automatic run_insn(input int g, input logic [2:0] c, input logic [2:0] r, input bit b2b);
    tr_q_t tr;
    tr = trace(c, r, nregs(g), lat(g));
    vld[g] = 1'b1; cls[g] = c; rn[g] = r;
    issued[g]++;
    @(posedge clk); #1;
    // keep valid high with junk operands while busy; it must be ignored
    cls[g] = 3'($urandom); rn[g] = 3'($urandom);
    foreach (tr[k]) begin
      @(negedge clk);
      chk($sformatf("g%0d c%0d r%0d cyc%0d out", g, c, r, k + 1), 32'(obs(g)), 32'(tr[k]));
      chk($sformatf("g%0d c%0d r%0d cyc%0d rdy", g, c, r, k + 1), 32'(rdy[g]),
          32'(k == tr.size() - 1));
    end
    vld[g] = 1'b0;
    if (!b2b) begin
      @(negedge clk);
      chk($sformatf("g%0d idle out", g), 32'(obs(g)), 32'h0);
      chk($sformatf("g%0d idle rdy", g), 32'(rdy[g]), 32'h1);
    end
  endtask

  // Bus exclusivity and done counting on every cycle of every instance.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!rst[g]) begin
        chk($sformatf("g%0d excl", g),
            32'(($countones(oe[g]) + 32'(pcr[g]) + 32'(roe[g])) <= 1), 32'h1);
        if (done[g]) dn[g]++;
      end
    end
  end

  initial begin
    for (int g = 0; g < NI; g++) begin
      rst[g] = 1'b1; vld[g] = 1'b0; cls[g] = '0; rn[g] = '0;
      issued[g] = 0; dn[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("g%0d reset out", g), 32'(obs(g)), 32'h0);
      chk($sformatf("g%0d reset rdy", g), 32'(rdy[g]), 32'h0);
      rst[g] = 1'b0;
    end
    #1;
    for (int g = 0; g < NI; g++)
      chk($sformatf("g%0d rdy after reset", g), 32'(rdy[g]), 32'h1);

    // back-to-back ALU_R r3, CPY r5, CPYPC r2
    run_insn(0, 3'd1, 3'd3, 1);
    run_insn(0, 3'd3, 3'd5, 1);
    run_insn(0, 3'd4, 3'd2, 0);
    // CPY r0 drives and captures the accumulator
    run_insn(0, 3'd3, 3'd0, 0);
    // SB r1 immediately followed by LB r2
    run_insn(0, 3'd7, 3'd1, 1);
    run_insn(0, 3'd6, 3'd2, 0);

    // RAM_LATENCY=3: LB r6
    run_insn(1, 3'd6, 3'd6, 0);
    run_insn(1, 3'd7, 3'd4, 1);
    run_insn(1, 3'd6, 3'd0, 0);

    // NUM_REGS=6: JMP r7 rejected, ALU_I r7 still legal
    run_insn(2, 3'd5, 3'd7, 0);
    run_insn(2, 3'd2, 3'd7, 0);

    // RAM_LATENCY=4: reset during WAIT aborts the load
    vld[2] = 1'b1; cls[2] = 3'd6; rn[2] = 3'd2;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    @(negedge clk);
    chk("g2 abort addr", 32'(obs(2)), 32'(mk(8'h01, 0, 0, 0, 1, 0, 0, 0, 0)));
    @(negedge clk);
    chk("g2 abort wait", 32'(obs(2)), 32'h0);
    rst[2] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("g2 abort in reset out", 32'(obs(2)), 32'h0);
      chk("g2 abort in reset rdy", 32'(rdy[2]), 32'h0);
    end
    rst[2] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("g2 after abort out", 32'(obs(2)), 32'h0);
      chk("g2 after abort rdy", 32'(rdy[2]), 32'h1);
    end
    run_insn(2, 3'd0, 3'd0, 0);

    // randomised class / register stream on every instance
    for (int g = 0; g < NI; g++)
      for (int i = 0; i < 40; i++)
        run_insn(g, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));

    @(negedge clk);
    for (int g = 0; g < NI; g++)
      chk($sformatf("g%0d done count", g), 32'(dn[g]), 32'(issued[g]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Parametrised bus-control sequencer for the softcore CPU datapath. It accepts one decoded instruction at a time from the instruction decoder over a valid/ready handshake and drives the one-hot register-file, PC and RAM enables cycle by cycle. It supports single-cycle register/ALU moves and multi-cycle RAM loads and stores, with a configurable RAM read latency. It pulses `insn_done` on the last cycle of every instruction. It sits between the instruction decoder and the register file / RAM bus.

## Interface
- `NUM_REGS`, 8: number of general registers; register 0 is the accumulator.
- `REG_SEL_W`, 3: width of `reg_num`; must satisfy 2^REG_SEL_W ≥ NUM_REGS.
- `RAM_LATENCY`, 1: cycles from the `ram_en` address cycle to valid read data; legal range 1..4.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `insn_valid` in 1: the decoder presents an instruction.
- `insn_ready` out 1: the sequencer accepts on this edge when both `insn_valid` and `insn_ready` are high.
- `insn_class` in 3: operation class; 0 NOP, 1 ALU_R, 2 ALU_I, 3 CPY, 4 CPYPC, 5 JMP, 6 LB, 7 SB.
- `reg_num` in REG_SEL_W: encoded operand register.
- `reg_out_en` out NUM_REGS: one-hot register drive onto the bus.
- `reg_write_en` out NUM_REGS: one-hot register capture from the bus.
- `reg_pc_read_en` out 1: PC drives the bus.
- `reg_pc_write_en` out 1: PC captures from the bus.
- `ram_en` out 1: RAM latches the address from the bus.
- `ram_we` out 1: RAM writes the bus data.
- `ram_out_en` out 1: RAM drives read data onto the bus.
- `insn_done` out 1: last cycle of the current instruction.
- `illegal_reg` out 1: one-cycle pulse when an instruction is rejected because `reg_num` ≥ NUM_REGS.

## Operation
- FSM states: IDLE, EXEC, ADDR, WAIT, DATA.
- All enables and `insn_done` are registered outputs, and each is high only during the cycles listed below.
- The sequencer latches `insn_class` and `reg_num` on acceptance.
- Single-cycle classes go to EXEC for one cycle, with `insn_done`=1 in that cycle:
  - NOP: no enables.
  - ALU_R: `reg_out_en[reg_num]`, `reg_write_en[0]`.
  - ALU_I: `reg_write_en[0]` only.
  - CPY: `reg_out_en[0]`, `reg_write_en[reg_num]`. With `reg_num`=0, both bits are set.
  - CPYPC: `reg_pc_read_en`, `reg_write_en[reg_num]`.
  - JMP: `reg_out_en[reg_num]`, `reg_pc_write_en`.
- LB takes RAM_LATENCY+1 cycles:
  - ADDR: `reg_out_en[0]`, `ram_en`.
  - WAIT: RAM_LATENCY−1 cycles with all enables low. A down-counter of width clog2(4)+1 controls this phase; it is loaded with RAM_LATENCY−1 on ADDR.
  - DATA: `ram_out_en`, `reg_write_en[reg_num]`, `insn_done`.
  - With RAM_LATENCY=1, WAIT is skipped (ADDR → DATA).
- SB takes 2 cycles regardless of RAM_LATENCY:
  - ADDR: `reg_out_en[0]`, `ram_en`.
  - DATA: `reg_out_en[reg_num]`, `ram_we`, `insn_done`.
- Illegal register: if `reg_num` ≥ NUM_REGS for any class other than NOP and ALU_I, the instruction is still accepted. It takes one EXEC cycle with no enables, and `insn_done`=1 and `illegal_reg`=1 in that cycle.
- Bus exclusivity invariant: at most one of {any `reg_out_en` bit, `reg_pc_read_en`, `ram_out_en`} is high in any cycle.

## Timing
- `insn_ready` is combinational: (state==IDLE) OR `insn_done` (registered), gated low while `rst`=1.
- Instruction accepted at edge N: its first action cycle is N+1. The next instruction can be accepted at the edge ending its `insn_done` cycle.
- Throughput:
  - Back-to-back single-cycle instructions issue at one per cycle, with `insn_done` held high continuously.
  - SB: one per 2 cycles.
  - LB: one per RAM_LATENCY+1 cycles.
- No `insn_valid` when ready: the FSM returns to IDLE and all outputs are 0 the following cycle.
- `insn_valid` low or inputs changing while the sequencer is busy are ignored; inputs are only sampled on acceptance.
- Reset:
  - All outputs are 0, the FSM is in IDLE, and the counter is 0.
  - `rst` asserted mid-LB/SB aborts the instruction: no `insn_done`, and all enables are 0 from the next cycle.
  - `insn_ready` is 1 in the first cycle after `rst` deasserts.

## Test plan
- Reset, then back-to-back ALU_R r3, CPY r5, CPYPC r2 at edges 1, 2, 3:
  - Cycle 2: `reg_out_en`=0x08, `reg_write_en`=0x01.
  - Cycle 3: `reg_out_en`=0x01, `reg_write_en`=0x20.
  - Cycle 4: `reg_pc_read_en`=1, `reg_write_en`=0x04.
  - `insn_done`=1 in cycles 2–4; `insn_ready` stays 1 throughout.
- RAM_LATENCY=3, LB r6 accepted at edge 1:
  - Cycle 2: `reg_out_en`=0x01, `ram_en`=1.
  - Cycles 3–4: all enables 0, `insn_ready`=0.
  - Cycle 5: `ram_out_en`=1, `reg_write_en`=0x40, `insn_done`=1.
- SB r1 followed immediately by LB r2 (RAM_LATENCY=1):
  - SB: ADDR in cycle 2; `reg_out_en`=0x02, `ram_we`=1, `insn_done`=1 in cycle 3.
  - LB is accepted at edge 3: ADDR in cycle 4, DATA in cycle 5.
- NUM_REGS=6, JMP with `reg_num`=7: single cycle with no enables, `illegal_reg`=1 and `insn_done`=1 in that cycle.
- RAM_LATENCY=4, `rst` pulsed during the WAIT phase of LB:
  - No `ram_out_en` or `insn_done` ever appears for that LB.
  - All outputs are 0 after reset.
  - A subsequent NOP completes in one cycle.
- Randomised class/register stream: check the bus-exclusivity invariant every cycle, and check that the number of `insn_done` cycles equals the number of accepted instructions.
